// File: rtl/instr_mem_loader.sv
// Boot-time loader: assembles little-endian words from a byte stream and writes
// them to consecutive instruction memory slots while holding the CPU in reset.
//
// state | meaning
// ------+----------------------------------------------------------
// IDLE  | no load since reset; waiting for start
// RECV  | accepting bytes of the current word (byte_ready high)
// WRITE | one-cycle memory write of the assembled word
// DONE  | last load completed; a new start may begin another load
module instr_mem_loader #(
   parameter int DEPTH = 64,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [CNT_W-1:0] num_words,
   input  logic             byte_valid,
   input  logic [7:0]       byte_data,
   output logic             byte_ready,
   output logic             mem_we,
   output logic [31:0]      mem_addr,
   output logic [31:0]      mem_wdata,
   output logic             busy,
   output logic             cpu_hold,
   output logic             done,
   output logic             err
);

   localparam int IDX_W = $clog2(DEPTH);
   localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

   typedef enum logic [1:0] {
      S_IDLE,
      S_RECV,
      S_WRITE,
      S_DONE
   } state_t;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic [IDX_W-1:0] word_idx_q, word_idx_d;
   logic [1:0]       byte_idx_q, byte_idx_d;
   logic [31:0]      word_buf_q, word_buf_d;
   logic [31:0]      mem_addr_q, mem_addr_d;
   logic [31:0]      mem_wdata_q, mem_wdata_d;
   logic             done_q, done_d;
   logic             err_q, err_d;

   logic num_ok;
   logic last_word;

   assign num_ok    = (num_words != '0) && (num_words <= DEPTH_C);
   assign last_word = (CNT_W'(word_idx_q) == (count_q - CNT_W'(1)));

   always_comb begin
      state_d     = state_q;
      count_d     = count_q;
      word_idx_d  = word_idx_q;
      byte_idx_d  = byte_idx_q;
      word_buf_d  = word_buf_q;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      done_d      = done_q;
      err_d       = err_q;

      case (state_q)
         S_IDLE, S_DONE: begin
            if (start) begin
               done_d = 1'b0;
               if (num_ok) begin
                  state_d    = S_RECV;
                  count_d    = num_words;
                  word_idx_d = '0;
                  byte_idx_d = '0;
                  err_d      = 1'b0;
               end else begin
                  err_d = 1'b1;
               end
            end
         end
         S_RECV: begin
            if (byte_valid) begin
               word_buf_d[{byte_idx_q, 3'b000} +: 8] = byte_data;
               byte_idx_d = byte_idx_q + 2'd1;
               // Address and data are latched here so they are stable for the whole WRITE cycle.
               if (byte_idx_q == 2'd3) begin
                  state_d     = S_WRITE;
                  mem_addr_d  = 32'({word_idx_q, 2'b00});
                  mem_wdata_d = {byte_data, word_buf_q[23:0]};
               end
            end
         end
         S_WRITE: begin
            if (last_word) begin
               state_d = S_DONE;
               done_d  = 1'b1;
            end else begin
               state_d    = S_RECV;
               word_idx_d = word_idx_q + IDX_W'(1);
               byte_idx_d = '0;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         count_q     <= '0;
         word_idx_q  <= '0;
         byte_idx_q  <= '0;
         word_buf_q  <= '0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         done_q      <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         count_q     <= count_d;
         word_idx_q  <= word_idx_d;
         byte_idx_q  <= byte_idx_d;
         word_buf_q  <= word_buf_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         done_q      <= done_d;
         err_q       <= err_d;
      end
   end

   assign byte_ready = (state_q == S_RECV);
   assign mem_we     = (state_q == S_WRITE);
   assign busy       = (state_q == S_RECV) || (state_q == S_WRITE);
   assign cpu_hold   = busy;
   assign mem_addr   = mem_addr_q;
   assign mem_wdata  = mem_wdata_q;
   assign done       = done_q;
   assign err        = err_q;

endmodule

// File: tb/tb_instr_mem_loader.sv
// Directed bench for instr_mem_loader with a behavioural instruction memory
// that records every write and answers pc-addressed reads.
module tb_instr_mem_loader;

   logic        clk;
   logic        rst_n;
   logic        start;
   logic [15:0] num_words;
   logic        byte_valid;
   logic [7:0]  byte_data;
   logic        byte_ready;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic        busy;
   logic        cpu_hold;
   logic        done;
   logic        err;

   instr_mem_loader #(.DEPTH(64), .CNT_W(16)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .start      (start),
      .num_words  (num_words),
      .byte_valid (byte_valid),
      .byte_data  (byte_data),
      .byte_ready (byte_ready),
      .mem_we     (mem_we),
      .mem_addr   (mem_addr),
      .mem_wdata  (mem_wdata),
      .busy       (busy),
      .cpu_hold   (cpu_hold),
      .done       (done),
      .err        (err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   logic [31:0] imem [0:63];
   logic [31:0] wr_addr [0:255];
   logic [31:0] wr_data [0:255];
   int          wr_cnt = 0;
   int          cyc = 0;

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (mem_we) begin
         imem[mem_addr[7:2]] <= mem_wdata;
         wr_addr[wr_cnt[7:0]] <= mem_addr;
         wr_data[wr_cnt[7:0]] <= mem_wdata;
         wr_cnt <= wr_cnt + 1;
      end
   end

   int n_checks = 0;
   int n_errors = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] fetch(input logic [31:0] pc);
      return imem[pc[7:2]];
   endfunction

   task automatic do_start(input logic [15:0] n);
      start     = 1'b1;
      num_words = n;
      @(negedge clk);
      start     = 1'b0;
   endtask

   task automatic send_byte(input logic [7:0] b);
      int g;
      g = 0;
      byte_valid = 1'b1;
      byte_data  = b;
      while (!byte_ready && g < 100) begin
         @(negedge clk);
         g++;
      end
      if (g >= 100) chk("byte_ready_timeout", 32'(byte_ready), 32'd1);
      @(negedge clk);
      byte_valid = 1'b0;
   endtask

   task automatic send_word(input logic [31:0] w, input int gap);
      for (int i = 0; i < 4; i++) begin
         send_byte(w[i*8 +: 8]);
         repeat (gap) @(negedge clk);
      end
   endtask

   task automatic wait_done(output int t, output logic hold_before);
      int g;
      g = 0;
      hold_before = cpu_hold;
      while (!done && g < 400) begin
         hold_before = cpu_hold;
         @(negedge clk);
         g++;
      end
      chk("done_seen", 32'(done), 32'd1);
      t = cyc;
   endtask

   int          t0, t1, base;
   logic        hb;
   logic [7:0]  basic_bytes [0:7];

   initial begin
      rst_n      = 1'b0;
      start      = 1'b0;
      num_words  = '0;
      byte_valid = 1'b0;
      byte_data  = '0;
      basic_bytes = '{8'h13, 8'h00, 8'h50, 8'h00, 8'h93, 8'h00, 8'hA0, 8'h00};
      repeat (3) @(negedge clk);
      chk("rst_flags", {26'd0, byte_ready, mem_we, busy, cpu_hold, done, err}, 32'd0);
      chk("rst_addr", mem_addr, 32'd0);
      chk("rst_wdata", mem_wdata, 32'd0);
      rst_n = 1'b1;
      @(negedge clk);

      // basic two-word load at full throughput
      base = wr_cnt;
      do_start(16'd2);
      chk("basic_busy", 32'(busy), 32'd1);
      chk("basic_ready", 32'(byte_ready), 32'd1);
      t0 = cyc;
      for (int i = 0; i < 8; i++) send_byte(basic_bytes[i]);
      wait_done(t1, hb);
      chk("basic_latency", 32'(t1 - t0), 32'd10);
      chk("basic_hold_before", 32'(hb), 32'd1);
      chk("basic_hold_drop", 32'(cpu_hold), 32'd0);
      chk("basic_busy_drop", 32'(busy), 32'd0);
      chk("basic_nwr", 32'(wr_cnt - base), 32'd2);
      chk("basic_a0", wr_addr[base], 32'h0);
      chk("basic_d0", wr_data[base], 32'h00500013);
      chk("basic_a1", wr_addr[base+1], 32'h4);
      chk("basic_d1", wr_data[base+1], 32'h00A00093);
      chk("fetch_pc0", fetch(32'h0), 32'h00500013);
      chk("fetch_pc4", fetch(32'h4), 32'h00A00093);
      chk("hold_addr", mem_addr, 32'h4);
      chk("hold_wdata", mem_wdata, 32'h00A00093);

      // backpressure gaps of 3 cycles between bytes
      base = wr_cnt;
      do_start(16'd1);
      send_word(32'hDEADBEEF, 3);
      wait_done(t1, hb);
      chk("gap_nwr", 32'(wr_cnt - base), 32'd1);
      chk("gap_addr", wr_addr[base], 32'h0);
      chk("gap_data", wr_data[base], 32'hDEADBEEF);

      // rejected starts; bytes offered outside RECV must not be consumed
      base = wr_cnt;
      do_start(16'd0);
      chk("rej0_err", 32'(err), 32'd1);
      chk("rej0_done", 32'(done), 32'd0);
      chk("rej0_busy", 32'(busy), 32'd0);
      chk("rej0_ready", 32'(byte_ready), 32'd0);
      byte_valid = 1'b1;
      byte_data  = 8'h5A;
      do_start(16'd65);
      repeat (3) @(negedge clk);
      chk("rej65_err", 32'(err), 32'd1);
      chk("rej65_busy", 32'(busy), 32'd0);
      chk("rej65_ready", 32'(byte_ready), 32'd0);
      chk("rej_nwr", 32'(wr_cnt - base), 32'd0);
      byte_valid = 1'b0;

      // full depth; a valid start clears err
      base = wr_cnt;
      do_start(16'd64);
      chk("full_err_clr", 32'(err), 32'd0);
      for (int w = 0; w < 64; w++) send_word({24'h332211, 8'(w)}, 0);
      wait_done(t1, hb);
      chk("full_nwr", 32'(wr_cnt - base), 32'd64);
      chk("full_last_addr", wr_addr[base+63], 32'hFC);
      chk("full_last_data", wr_data[base+63], 32'h3322113F);
      chk("full_w16_addr", wr_addr[base+16], 32'h40);
      chk("full_w16_fetch", fetch(32'h40), 32'h33221110);

      // reset after two bytes of word 1
      base = wr_cnt;
      do_start(16'd2);
      send_word(32'hCAFEF00D, 0);
      send_byte(8'h01);
      send_byte(8'h02);
      #1 rst_n = 1'b0;
      #1;
      chk("midrst_flags", {26'd0, byte_ready, mem_we, busy, cpu_hold, done, err}, 32'd0);
      chk("midrst_addr", mem_addr, 32'd0);
      chk("midrst_wdata", mem_wdata, 32'd0);
      repeat (2) @(negedge clk);
      chk("midrst_nwr", 32'(wr_cnt - base), 32'd1);
      chk("midrst_w0", wr_data[base], 32'hCAFEF00D);
      rst_n = 1'b1;
      @(negedge clk);
      base = wr_cnt;
      do_start(16'd1);
      send_word(32'h12345678, 0);
      wait_done(t1, hb);
      chk("restart_nwr", 32'(wr_cnt - base), 32'd1);
      chk("restart_addr", wr_addr[base], 32'h0);
      chk("restart_data", wr_data[base], 32'h12345678);

      // start while busy is ignored
      base = wr_cnt;
      do_start(16'd2);
      send_byte(8'hAA);
      send_byte(8'hBB);
      do_start(16'd5);
      send_byte(8'hCC);
      send_byte(8'hDD);
      send_word(32'h87654321, 0);
      wait_done(t1, hb);
      repeat (12) @(negedge clk);
      chk("busy_start_nwr", 32'(wr_cnt - base), 32'd2);
      chk("busy_start_d0", wr_data[base], 32'hDDCCBBAA);
      chk("busy_start_a1", wr_addr[base+1], 32'h4);
      chk("busy_start_d1", wr_data[base+1], 32'h87654321);
      chk("busy_start_err", 32'(err), 32'd0);
      chk("busy_start_idle", 32'(busy), 32'd0);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/instr_mem_loader.md
# instr_mem_loader

Boot-time writer for the CPU instruction memory. Accepts a byte stream over a valid/ready handshake, assembles little-endian 32-bit instruction words, and writes them into consecutive word slots of the instruction memory write port, starting at byte address 0. While loading, it holds the CPU core in reset, so fetch from the `pc`/`instr` read side starts only on a fully loaded image.

## Interface
- `DEPTH`, 64: instruction memory capacity in 32-bit words.
- `CNT_W`, 16: width of the word-count input.
- `clk`  input  1  single system clock; all state changes on the rising edge.
- `rst_n`  input  1  asynchronous, active-low reset.
- `start`  input  1  begin a load. Sampled only in IDLE or DONE.
- `num_words`  input  CNT_W  number of words to load. Latched on an accepted `start`.
- `byte_valid`  input  1  `byte_data` is valid.
- `byte_data`  input  8  next image byte.
- `byte_ready`  output  1  loader accepts a byte this cycle.
- `mem_we`  output  1  instruction memory write enable, one-cycle pulse per word.
- `mem_addr`  output  32  byte address, word-aligned (word index = `mem_addr`>>2), matching the `pc` addressing of the read side.
- `mem_wdata`  output  32  assembled instruction word.
- `busy`  output  1  load in progress (RECV or WRITE).
- `cpu_hold`  output  1  equals `busy`; drives the core's reset hold.
- `done`  output  1  level; the last load completed.
- `err`  output  1  level; the last `start` was rejected.

## Operation
- States: IDLE, RECV, WRITE, DONE.
- IDLE and DONE:
  - `byte_ready`=0 and `mem_we`=0.
  - `start` with 1 ≤ `num_words` ≤ `DEPTH`: go to RECV, latch the count, clear the word index and byte index, clear `done` and `err`.
  - `start` with `num_words`=0 or >`DEPTH`: set `err`=1, clear `done`, stay in the current state with no writes.
- RECV:
  - `byte_ready`=1.
  - Each handshake (`byte_valid` & `byte_ready`) stores `byte_data` into lane `byte_idx`. Byte 0 goes to [7:0], byte 3 to [31:24].
  - `byte_idx` increments on each handshake.
  - The 4th handshake moves the state to WRITE.
  - If `byte_valid` is low, the loader waits indefinitely with no timeout.
- WRITE:
  - `byte_ready`=0, `mem_we`=1, `mem_addr`={word_idx,2'b00}, `mem_wdata`=assembled word.
  - Stays in WRITE for exactly one cycle.
  - If word_idx = count-1: go to DONE and set `done`=1.
  - Otherwise: increment word_idx, clear `byte_idx`, return to RECV.
- `start` is ignored while `busy`.
- `byte_valid` is ignored outside RECV; no byte is consumed outside RECV.
- The word index never exceeds `DEPTH`-1; the last possible address is (`DEPTH`-1)*4.
- Asynchronous reset, including mid-load:
  - State goes to IDLE and all outputs go to 0.
  - The partial word is discarded; no write is issued.
  - Words already written stay in memory. The loader does not clear memory.

## Timing
- Reset values: `byte_ready`=0, `mem_we`=0, `mem_addr`=0, `mem_wdata`=0, `busy`=0, `cpu_hold`=0, `done`=0, `err`=0.
- Accepted `start` at edge E: `busy`=1 and `byte_ready`=1 in the cycle after E.
- Bytes transfer on a rising edge where `byte_valid` & `byte_ready` are both high.
- 4th byte accepted at edge N:
  - `mem_we` is high for the cycle following N.
  - The memory captures the word at edge N+1.
  - `byte_ready` returns high after N+1, unless the word was the last.
- Final word written at edge W: `busy`=0, `cpu_hold`=0 and `done`=1 in the cycle after W.
- Maximum throughput with `byte_valid` held high: 1 word per 5 cycles. A load of n words takes 5n cycles from the first `byte_ready` to `done`.
- `err` rises in the cycle after the rejected `start`.
- `mem_addr` and `mem_wdata` are registered and stable throughout the `mem_we` cycle. Outside WRITE they hold their last values.

## Test plan
- Basic load:
  - Stimulus: `start` with `num_words`=2; bytes 13 00 50 00 93 00 A0 00 with `byte_valid` held high.
  - Required: write 0x00500013 at address 0x0, then 0x00A00093 at address 0x4.
  - Required: `done`=1 exactly 10 cycles after the first `byte_ready`, and `cpu_hold` drops in the same cycle.
  - Required: an instrMem read-back of `pc`=0 and `pc`=4 returns both words.
- Backpressure gaps:
  - Stimulus: deassert `byte_valid` for 3 cycles between every byte; load 1 word.
  - Required: still exactly one `mem_we` pulse with the correct data; no byte is duplicated or dropped.
- Rejected starts:
  - Stimulus: `num_words`=0, then `num_words`=65 with `DEPTH`=64.
  - Required: `err`=1, `busy`=0, `byte_ready`=0, and no `mem_we` pulse. A following valid `start` clears `err`.
- Full depth:
  - Stimulus: `num_words`=64.
  - Required: 64 writes; the last `mem_addr` is 0xFC; word 16 lands at address 0x40.
- Reset mid-word:
  - Stimulus: assert `rst_n`=0 after 2 bytes of word 1.
  - Required: all outputs are 0 immediately, no write is issued, and the state is IDLE.
  - Required: a new load then starts cleanly at address 0.
- `start` while busy:
  - Stimulus: pulse `start` with `num_words`=5 during a 2-word load.
  - Required: the pulse is ignored; the load completes with 2 words.
